// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store unit, IDLE/ACCESS/RESP handshake with fault checks
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_store_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_misalign_o,
  output logic                  resp_illegal_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  output logic [2:0]            mem_funct3_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_is_store;
  logic [2:0]              r_funct3;
  logic [DATA_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic                    w_accept;
  logic                    w_illegal;
  logic                    w_misalign;
  logic                    w_go;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [DATA_WIDTH-1:0]   w_load;

  assign w_accept = req_valid_i && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_state_next = ACCESS;
      end
      ACCESS: w_state_next = RESP;
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request fields are captured once and held until the unit returns to IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_is_store <= req_is_store_i;
      r_funct3   <= req_funct3_i;
      r_addr     <= req_addr_i;
      r_wdata    <= req_wdata_i;
    end
  end

  // Misalignment is only reported when the code is legal, so one flag at most
  always_comb begin
    if (r_is_store) begin
      w_illegal = !(r_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_illegal = !(r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
    w_misalign = 1'b0;
    if (!w_illegal) begin
      case (r_funct3[1:0])
        2'b01:   w_misalign = r_addr[0];
        2'b10:   w_misalign = |r_addr[1:0];
        default: w_misalign = 1'b0;
      endcase
    end
  end

  assign w_go = (r_state == ACCESS) && !w_illegal && !w_misalign;

  always_comb begin
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_funct3_o  = 3'b000;
    mem_write_o   = 1'b0;
    mem_read_o    = 1'b0;
    if (w_go) begin
      mem_addr_o    = r_addr;
      mem_wr_data_o = r_wdata;
      mem_funct3_o  = r_funct3;
      mem_write_o   = r_is_store;
      mem_read_o    = !r_is_store;
    end
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rd_data_i[7:0];
      2'b01:   w_byte = mem_rd_data_i[15:8];
      2'b10:   w_byte = mem_rd_data_i[23:16];
      default: w_byte = mem_rd_data_i[31:24];
    endcase
    w_half = r_addr[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
    case (r_funct3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = mem_rd_data_i;
    endcase
  end

  // Response registers load only in ACCESS, so they hold through a RESP stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_rdata_o    <= '0;
      resp_misalign_o <= 1'b0;
      resp_illegal_o  <= 1'b0;
    end else if (r_state == ACCESS) begin
      resp_rdata_o    <= (w_go && !r_is_store) ? w_load : '0;
      resp_misalign_o <= w_misalign;
      resp_illegal_o  <= w_illegal;
    end
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of address, store data and load data.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid_i  input  1  pipeline presents a memory operation.
REQ-005 req_ready_o  output  1  unit can accept an operation this cycle.
REQ-006 req_is_store_i  input  1  1 = store, 0 = load.
REQ-007 req_funct3_i  input  3  RV32I load/store funct3.
REQ-008 req_addr_i  input  DATA_WIDTH  byte address (rs1 + imm).
REQ-009 req_wdata_i  input  DATA_WIDTH  store data (rs2), unaligned in the low bits.
REQ-010 resp_valid_o  output  1  completion available.
REQ-011 resp_ready_i  input  1  pipeline consumes the completion.
REQ-012 resp_rdata_o  output  DATA_WIDTH  extended load result; 0 for stores and faults.
REQ-013 resp_misalign_o  output  1  operation faulted as misaligned.
REQ-014 resp_illegal_o  output  1  operation faulted as illegal funct3.
REQ-015 mem_addr_o  output  DATA_WIDTH  byte address to data memory.
REQ-016 mem_wr_data_o  output  DATA_WIDTH  store data to data memory, unshifted; the memory performs lane placement from mem_addr_o[1:0].
REQ-017 mem_funct3_o  output  3  size code to data memory.
REQ-018 mem_write_o / mem_read_o  output  1 each  write and read strobes.
REQ-019 mem_rd_data_i  input  DATA_WIDTH  full aligned word, combinationally valid in the same cycle as mem_addr_o.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; req_ready_o = 1 only in IDLE.
REQ-021 Handshake: an operation is accepted when req_valid_i && req_ready_o; the request fields are latched on acceptance and held internally until return to IDLE.
REQ-022 IDLE -> ACCESS on acceptance; ACCESS -> RESP unconditionally after one cycle; RESP -> IDLE when resp_ready_i = 1.
REQ-023 Latency: acceptance at cycle N, memory access at cycle N+1, resp_valid_o = 1 from cycle N+2; the next acceptance is at the earliest cycle N+3.
REQ-024 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; any other code sets resp_illegal_o.
REQ-025 Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 00; sets resp_misalign_o.
REQ-026 Illegal takes priority over misaligned; exactly one flag is set per faulting operation.
REQ-027 Faulting operation: no strobe in ACCESS and resp_rdata_o = 0.
REQ-028 ACCESS cycle, legal aligned operation: mem_addr_o, mem_funct3_o and mem_wr_data_o driven from the latched fields; mem_write_o = 1 for a store, mem_read_o = 1 for a load, each for exactly one cycle.
REQ-029 Outside ACCESS: mem_write_o = 0, mem_read_o = 0, mem_addr_o = 0, mem_wr_data_o = 0, mem_funct3_o = 0.
REQ-030 Load extraction: in ACCESS, select the byte at addr[1:0] or the halfword at addr[1] from mem_rd_data_i, extend per funct3 (signed for LB/LH, zero for LBU/LHU; LW passes the word), and register the result into resp_rdata_o.
REQ-031 resp_rdata_o, resp_misalign_o and resp_illegal_o are stable throughout RESP, including while resp_ready_i = 0 stalls the unit.
REQ-032 req_valid_i presented during ACCESS or RESP is ignored: no latch and no side effect.

Reset
REQ-033 When rst_n = 0 at a clock edge: state becomes IDLE and resp_valid_o, resp_rdata_o, resp_misalign_o and resp_illegal_o become 0.
REQ-034 Reset asserted during ACCESS or RESP abandons the operation; no memory strobe occurs in the cycle following reset.
REQ-035 After reset deassertion, req_ready_o = 1.

Verification
REQ-036 SB with addr 0x103, wdata 0xAABBCCDD -> one ACCESS cycle with mem_write_o = 1, mem_addr_o = 0x103, mem_funct3_o = 000, mem_wr_data_o = 0xAABBCCDD; then a response with rdata 0 and no fault flags.
REQ-037 LB at 0x102 with memory word 0x1280FF34 -> resp_rdata_o = 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x102 -> 0x00001280.
REQ-038 LH at 0x101 -> no strobe, resp_misalign_o = 1, resp_rdata_o = 0; SW at 0x102 -> no strobe, resp_misalign_o = 1.
REQ-039 Load with funct3 011 at 0x101 -> resp_illegal_o = 1, resp_misalign_o = 0, no strobe.
REQ-040 resp_ready_i held 0 for 5 cycles during RESP -> outputs stable and req_ready_o = 0 throughout; a req_valid_i pulse during the stall is dropped.
REQ-041 rst_n = 0 during ACCESS of a store -> state IDLE and resp_valid_o = 0 next cycle, with no further mem_write_o.
